// File: rtl/rca_byte_sequencer.sv
// Byte-serial wide adder controller driving one external 8-bit ripple-carry adder, LSB first.
// Optional macro SEQ_SETTLE_EN adds a SETTLE state holding adder inputs SETTLE_CYCLES extra cycles per byte.
module rca_byte_sequencer #(
  parameter int NBYTES        = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [8*NBYTES-1:0] op_a,
  input  logic [8*NBYTES-1:0] op_b,
  input  logic                cin,
  output logic                busy,
  output logic                done,
  output logic [8*NBYTES-1:0] result,
  output logic                cout,
  output logic [7:0]          add_a,
  output logic [7:0]          add_b,
  output logic                add_cin,
  input  logic [7:0]          add_sum,
  input  logic                add_cout
);

  localparam int W  = 8 * NBYTES;
  localparam int IW = $clog2(NBYTES);

`ifdef SEQ_SETTLE_EN
  typedef enum logic [1:0] {ST_IDLE, ST_ADD, ST_SETTLE, ST_DONE} state_t;
  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  logic [CW-1:0] settle_cnt_reg;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_ADD, ST_DONE} state_t;
`endif

  state_t        state_reg, state_next;
  logic [IW-1:0] idx_reg;
  logic [W-1:0]  a_reg, b_reg;
  logic [W-1:0]  result_reg;
  logic          cout_reg;
  logic [7:0]    add_a_reg, add_b_reg;
  logic          carry_reg;
  logic          accept, capture, last_byte;

  assign last_byte = (idx_reg == IW'(NBYTES - 1));
  assign accept    = start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));

  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    capture    = 1'b0;
    case (state_reg)
      ST_IDLE: if (start) state_next = ST_ADD;
      ST_ADD: begin
`ifdef SEQ_SETTLE_EN
        if (SETTLE_CYCLES == 0) capture = 1'b1;
        else                    state_next = ST_SETTLE;
`else
        capture = 1'b1;
`endif
      end
`ifdef SEQ_SETTLE_EN
      ST_SETTLE: if (settle_cnt_reg == CW'(SETTLE_CYCLES - 1)) capture = 1'b1;
`endif
      ST_DONE: state_next = start ? ST_ADD : ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    if (capture) state_next = last_byte ? ST_DONE : ST_ADD;
  end

  // Adder inputs come straight from flops; the next byte is preloaded on each capture edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_reg    <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      result_reg <= '0;
      cout_reg   <= 1'b0;
      add_a_reg  <= '0;
      add_b_reg  <= '0;
      carry_reg  <= 1'b0;
    end else if (accept) begin
      idx_reg   <= '0;
      a_reg     <= op_a;
      b_reg     <= op_b;
      add_a_reg <= op_a[7:0];
      add_b_reg <= op_b[7:0];
      carry_reg <= cin;
    end else if (capture) begin
      result_reg[8*idx_reg +: 8] <= add_sum;
      if (last_byte) begin
        cout_reg  <= add_cout;
        idx_reg   <= '0;
        add_a_reg <= '0;
        add_b_reg <= '0;
        carry_reg <= 1'b0;
      end else begin
        idx_reg   <= idx_reg + 1'b1;
        a_reg     <= a_reg >> 8;
        b_reg     <= b_reg >> 8;
        add_a_reg <= a_reg[15:8];
        add_b_reg <= b_reg[15:8];
        carry_reg <= add_cout;
      end
    end
  end

`ifdef SEQ_SETTLE_EN
  always_ff @(posedge clk) begin
    if (rst)                          settle_cnt_reg <= '0;
    else if (state_reg == ST_SETTLE)  settle_cnt_reg <= settle_cnt_reg + 1'b1;
    else                              settle_cnt_reg <= '0;
  end
  assign busy = (state_reg == ST_ADD) || (state_reg == ST_SETTLE);
`else
  assign busy = (state_reg == ST_ADD);
`endif

  assign done    = (state_reg == ST_DONE);
  assign result  = result_reg;
  assign cout    = cout_reg;
  assign add_a   = add_a_reg;
  assign add_b   = add_b_reg;
  assign add_cin = carry_reg;

endmodule

// File: tb/tb_rca_byte_sequencer.sv
// Self-checking bench for rca_byte_sequencer (NBYTES=4) with a behavioural 8-bit RCA and a result scoreboard.
module tb_rca_byte_sequencer;
  localparam int NB = 4;
  localparam int W  = 8 * NB;
`ifdef SEQ_SETTLE_EN
  localparam int SC = 2;
`else
  localparam int SC = 0;
`endif
  localparam int LAT = NB * (1 + SC) + 1;

  logic clk = 1'b0;
  logic rst, start, cin, busy, done, cout, add_cin, add_cout;
  logic [W-1:0] op_a, op_b, result;
  logic [7:0] add_a, add_b, add_sum;

  rca_byte_sequencer #(.NBYTES(NB), .SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b), .cin(cin),
    .busy(busy), .done(done), .result(result), .cout(cout),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout)
  );

  assign {add_cout, add_sum} = 9'(add_a) + 9'(add_b) + 9'(add_cin);

  always #5 clk = ~clk;

  typedef struct { logic [W-1:0] res; logic co; } exp_t;
  typedef struct { logic [W-1:0] a; logic [W-1:0] b; logic c; logic [W-1:0] res; logic co; } vec_t;

  exp_t sb_q[$];
  logic [7:0] a_log[$];
  logic cin_log[$];
  int n_checks = 0, n_fail = 0;
  int cyc = 0, done_cyc = 0, n_done = 0;
  bit done_seen = 0;
  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic sample();
    if (done) begin
      done_seen = 1;
      done_cyc = cyc;
      n_done++;
      if (sb_q.size() == 0) check("unexpected_done", 1, 0);
      else begin
        exp_t e = sb_q.pop_front();
        check("result", 64'(result), 64'(e.res));
        check("cout", 64'(cout), 64'(e.co));
      end
      $display("done @cyc %0d result=0x%08h cout=%0d", cyc, result, cout);
    end
    if (busy) begin
      a_log.push_back(add_a);
      cin_log.push_back(add_cin);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    sample();
  endtask

  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input logic [W-1:0] res, input logic co);
    exp_t e;
    op_a = a; op_b = b; cin = c; start = 1'b1;
    e.res = res; e.co = co;
    sb_q.push_back(e);
    a_log.delete(); cin_log.delete();
    cyc = 0; done_seen = 0;
    step();
    start = 1'b0;
    check("busy_after_start", 64'(busy), 64'(1));
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done_seen && n < 200) begin step(); n++; end
    if (!done_seen) check("done_timeout", 0, 1);
    else check("done_latency", 64'(done_cyc), 64'(LAT));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 64'(busy), 0);
    check({tag, "_done"}, 64'(done), 0);
    check({tag, "_result"}, 64'(result), 0);
    check({tag, "_cout"}, 64'(cout), 0);
    check({tag, "_add_a"}, 64'(add_a), 0);
    check({tag, "_add_b"}, 64'(add_b), 0);
    check({tag, "_add_cin"}, 64'(add_cin), 0);
  endtask

  initial begin
    logic [7:0] exp_bytes [4];
    logic [W:0] sum;
    logic [W-1:0] ra, rb;
    logic rc;
    int d0;

    vecs[0] = '{32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0};
    vecs[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1};
    vecs[2] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1};
    vecs[3] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1};
    vecs[4] = '{32'h0000FFFF, 32'h00000001, 1'b0, 32'h00010000, 1'b0};
    vecs[5] = '{32'hA5A5A5A5, 32'h5A5A5A5A, 1'b1, 32'h00000000, 1'b1};
    vecs[6] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b0};
    vecs[7] = '{32'h00FF00FF, 32'h00010001, 1'b0, 32'h01000100, 1'b0};

    rst = 1'b1; start = 1'b0; op_a = '0; op_b = '0; cin = 1'b0;
    step(); step();
    rst = 1'b0;
    check_reset_outputs("reset");
    step();
    check_reset_outputs("idle");

    // Plain add: add_a byte order with per-byte hold length.
    launch(vecs[0].a, vecs[0].b, vecs[0].c, vecs[0].res, vecs[0].co);
    wait_done();
    check("add_a_len", 64'(a_log.size()), 64'(NB * (1 + SC)));
    exp_bytes[0] = 8'h78; exp_bytes[1] = 8'h56; exp_bytes[2] = 8'h34; exp_bytes[3] = 8'h12;
    for (int i = 0; i < a_log.size() && i < NB * (1 + SC); i++)
      check($sformatf("add_a_seq%0d", i), 64'(a_log[i]), 64'(exp_bytes[i / (1 + SC)]));
    check("idle_add_a", 64'(add_a), 0);
    step();
    check("done_one_cycle", 64'(done), 0);

    // Full ripple: carry into bytes 1..3 must be 1.
    launch(vecs[1].a, vecs[1].b, vecs[1].c, vecs[1].res, vecs[1].co);
    wait_done();
    for (int i = 0; i < cin_log.size() && i < NB * (1 + SC); i++)
      check($sformatf("add_cin_seq%0d", i), 64'(cin_log[i]), 64'((i / (1 + SC)) != 0));
    step();

    // Carry-in with an ignored start in cycle 2.
    d0 = n_done;
    launch(vecs[2].a, vecs[2].b, vecs[2].c, vecs[2].res, vecs[2].co);
    step();
    op_a = 32'h01010101; op_b = 32'h02020202; cin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    wait_done();
    for (int i = 0; i < 4; i++) step();
    check("single_done", 64'(n_done - d0), 1);

    // Table of further vectors.
    for (int i = 3; i < 8; i++) begin
      launch(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].res, vecs[i].co);
      wait_done();
      step();
    end

    // Random vectors against a reference sum.
    for (int i = 0; i < 6; i++) begin
      ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1));
      sum = {1'b0, ra} + {1'b0, rb} + (W+1)'(rc);
      launch(ra, rb, rc, sum[W-1:0], sum[W]);
      wait_done();
      step();
    end

    // Back-to-back: start in the done cycle.
    launch(32'h00000005, 32'h00000006, 1'b0, 32'h0000000B, 1'b0);
    wait_done();
    launch(32'h00000001, 32'h00000002, 1'b0, 32'h00000003, 1'b0);
    wait_done();

    // Reset in cycle 2 of a new operation aborts with no done.
    d0 = n_done;
    step();
    launch(32'h11111111, 32'h22222222, 1'b0, 32'h33333333, 1'b0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    sb_q.delete();
    check_reset_outputs("abort");
    for (int i = 0; i < LAT + 2; i++) step();
    check("abort_no_done", 64'(n_done - d0), 0);
    check("abort_busy", 64'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/rca_byte_sequencer.md
# rca_byte_sequencer

Multi-cycle controller that performs an NBYTES-wide addition by sequencing one external 8-bit ripple-carry adder one byte per step, LSB first, chaining the carry through a register. It sits between a requester issuing `start`/operands and the shared 8-bit RCA instance. It provides wide additions without widening the carry chain. It also holds the adder inputs at zero when idle, so timing and power measurements of the RCA see activity only during real operations.

## Interface
Parameters:
- `NBYTES`, default 4: operand width in bytes (W = 8*NBYTES); legal range 2..16.
- `SETTLE_CYCLES`, default 1: extra hold cycles per byte; used only when `SEQ_SETTLE_EN` is defined.

Ports:
- `clk`  input  1  : single clock; all logic on rising edge.
- `rst`  input  1  : synchronous, active-high reset.
- `start`  input  1  : request; sampled only in IDLE or DONE.
- `op_a`  input  W  : operand A; captured on accepted `start`.
- `op_b`  input  W  : operand B; captured on accepted `start`.
- `cin`  input  1  : carry-in to byte 0; captured on accepted `start`.
- `busy`  output  1  : high while bytes are being processed.
- `done`  output  1  : one-cycle pulse; `result`/`cout` valid from this cycle.
- `result`  output  W  : registered sum; held until the next accepted `start`.
- `cout`  output  1  : registered final carry out of MSB byte.
- `add_a`  output  8  : to adder `a`.
- `add_b`  output  8  : to adder `b`.
- `add_cin`  output  1  : to adder `cin`.
- `add_sum`  input  8  : from adder `Sum`; combinational response.
- `add_cout`  input  1  : from adder carry/overflow output.

## Operation
- States: IDLE, ADD, (SETTLE when `SEQ_SETTLE_EN`), DONE.
- IDLE:
  - `start`=1 captures `op_a`, `op_b` and `cin` into the carry register.
  - Sets byte index `idx`=0 and moves to ADD.
- ADD, byte `idx`:
  - Adder inputs: `add_a`=A[8*idx+:8], `add_b`=B[8*idx+:8], `add_cin`=carry register. All are driven from registers only, so the adder sees no combinational glitches from this block.
  - On the capturing edge: `result[8*idx+:8]` <= `add_sum`; carry register <= `add_cout`.
  - If `idx`=NBYTES-1, go to DONE and set `cout` <= `add_cout`; otherwise `idx`++.
- DONE:
  - `done`=1 for exactly one cycle.
  - `start` in DONE is accepted exactly as in IDLE (back-to-back operation). Otherwise go to IDLE.
- IDLE and DONE drive `add_a`=0, `add_b`=0, `add_cin`=0.
- `start` while in ADD or SETTLE is ignored, not queued.
- `result` bytes not yet written during an operation keep their previous values. `result` is fully valid only at and after `done`.
- Arithmetic: {`cout`,`result`} = `op_a` + `op_b` + `cin`, modulo 2^(W+1); unsigned, no saturation.

## Timing
- Reset (`rst`=1 at an edge):
  - State IDLE, `idx`=0, carry register 0.
  - `busy`=0, `done`=0, `result`=0, `cout`=0, `add_*`=0.
  - Reset has priority over `start` and aborts any operation in progress with no `done`.
- Without `SEQ_SETTLE_EN`:
  - `start` high in cycle 0; ADD occupies cycles 1..NBYTES; `done` is high in cycle NBYTES+1.
  - `busy` is high in cycles 1..NBYTES.
- With `SEQ_SETTLE_EN`:
  - Each byte occupies 1+SETTLE_CYCLES cycles.
  - The adder inputs are stable for the whole period; capture happens on the last edge only.
  - `done` is high in cycle NBYTES*(1+SETTLE_CYCLES)+1.
- Back-to-back: `start` in the `done` cycle makes `busy`=1 in the next cycle.
- The adder path (`add_*` registers → RCA → `add_sum` capture) must close in one clock period (one period plus SETTLE_CYCLES with the macro).

## Configuration
- Macro: `SEQ_SETTLE_EN`.
- Defined:
  - SETTLE state and a settle counter are compiled in.
  - The counter counts SETTLE_CYCLES cycles after each ADD cycle before capture.
  - This allows the RCA to be clocked faster than its ripple delay, as a multicycle path.
- Undefined:
  - No SETTLE state or counter.
  - One cycle per byte; `SETTLE_CYCLES` is ignored.

## Test plan
All scenarios use NBYTES=4 and no macro unless stated.
- Reset: hold `rst` 2 cycles, then release. Required: `busy`=0, `done`=0, `result`=0x00000000, `cout`=0, `add_a`/`add_b`/`add_cin`=0.
- Plain add: 0x12345678 + 0x11111111, `cin`=0, `start` in cycle 0. Required: `done` in cycle 5 only, `result`=0x23456789, `cout`=0. `add_a` sequence is 0x78, 0x56, 0x34, 0x12.
- Full ripple carry: 0xFFFFFFFF + 0x00000001, `cin`=0. Required: `result`=0x00000000, `cout`=1. `add_cin` sequence is 0, 1, 1, 1.
- Carry-in and ignored start: 0xFFFFFFFF + 0x00000000, `cin`=1. Pulse `start` again in cycle 2 with different operands. Required: `result`=0x00000000, `cout`=1, only one `done`.
- Back-to-back: assert `start` in the `done` cycle with 0x00000001 + 0x00000002. Required: second `done` 5 cycles later, `result`=0x00000003. Then a reset in cycle 2 of a new operation returns all outputs to their reset values with no `done`.
- Settle (`SEQ_SETTLE_EN`, SETTLE_CYCLES=2): repeat the plain add. Required: each `add_a` byte is held 3 cycles, `done` in cycle 13, `result`=0x23456789.
